// File: rtl/clock_pkg.sv
// Shared definitions for the seconds tick generator: run/pause state encoding
// and the default divider / debounce constants.
package clock_pkg;

  // Run/pause control state of the tick generator.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  // clk cycles per seconds tick (50 MHz board clock).
  localparam int unsigned DEFAULT_DIV       = 50_000_000;
  // Consecutive stable cycles (10 ms at 50 MHz) before a button level is accepted.
  localparam int unsigned DEFAULT_DB_CYCLES = 500_000;

  // The opposite run/pause state; unknown encodings fall back to RUN.
  function automatic run_state_e toggle_state(input run_state_e cur);
    run_state_e nxt;
    case (cur)
      ST_RUN:   nxt = ST_PAUSE;
      ST_PAUSE: nxt = ST_RUN;
      default:  nxt = ST_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioning: 2-flop synchronizer, counter debouncer and a
// single-cycle press pulse on the debounced rising edge.
module btn_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned     DB_W    = $clog2(DB_CYCLES + 1);
  // The level flips on the DB_CYCLES-th consecutive mismatching cycle.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

  logic            sync_q1_r;
  logic            sync_q2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic [DB_W-1:0] db_cnt_nxt_s;
  logic            level_r;
  logic            level_nxt_s;
  logic            level_d_r;
  logic            press_s;

  // Two-stage synchronizer bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
    end else begin
      sync_q1_r <= btn_raw;
      sync_q2_r <= sync_q1_r;
    end
  end

  // Debounce: count consecutive disagreeing cycles, adopt the new level at terminal count.
  always_comb begin
    db_cnt_nxt_s = DB_ZERO;
    level_nxt_s  = level_r;
    if (sync_q2_r != level_r) begin
      if (db_cnt_r == DB_LAST) begin
        level_nxt_s  = sync_q2_r;
        db_cnt_nxt_s = DB_ZERO;
      end else begin
        level_nxt_s  = level_r;
        db_cnt_nxt_s = db_cnt_r + DB_ONE;
      end
    end else begin
      // Agreement breaks any run of mismatches.
      db_cnt_nxt_s = DB_ZERO;
      level_nxt_s  = level_r;
    end
  end

  // Debounce state and the delayed level used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_r  <= DB_ZERO;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
    end else begin
      db_cnt_r  <= db_cnt_nxt_s;
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
    end
  end

  // Press pulse on the 0->1 debounced transition; holding or releasing adds nothing.
  always_comb begin
    press_s = level_r & ~level_d_r;
  end

  assign press = press_s;

endmodule

// File: rtl/sec_tick_gen.sv
// Seconds tick generator: prescales clk down to a one-cycle inc_sec pulse per
// DIV cycles, with run/pause and single-step buttons, a time-set hold, and a
// 1 Hz blink derived from the prescaler count.
module sec_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned DIV       = DEFAULT_DIV,
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run_btn,
  input  logic step_btn,
  input  logic set,
  output logic inc_sec,
  output logic blink,
  output logic running
);

  localparam int unsigned      CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             run_press_s;
  logic             step_press_s;
  run_state_e       state_r;
  run_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             step_pulse_r;
  logic             step_pulse_nxt_s;
  logic             inc_sec_s;
  logic             blink_s;
  logic             running_s;

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES)
  ) u_run_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (run_btn),
    .press   (run_press_s)
  );

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .press   (step_press_s)
  );

  // Run/pause state register; reset lands in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a run press toggles; set has no influence on the state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (run_press_s) begin
          state_nxt_s = toggle_state(state_r);
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (run_press_s) begin
          state_nxt_s = toggle_state(state_r);
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Prescaler: forced to zero under set, wraps at DIV-1 in RUN, frozen in PAUSE.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (set) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Step request: only honoured while paused, and a simultaneous run press wins.
  always_comb begin
    step_pulse_nxt_s = 1'b0;
    if (step_press_s && (state_r == ST_PAUSE) && !run_press_s && !set) begin
      step_pulse_nxt_s = 1'b1;
    end else begin
      step_pulse_nxt_s = 1'b0;
    end
  end

  // Prescaler count and the registered manual-step pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r        <= CNT_ZERO;
      step_pulse_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      step_pulse_r <= step_pulse_nxt_s;
    end
  end

  // Output decode from registered state; set masks every tick source.
  always_comb begin
    inc_sec_s = 1'b0;
    if (set) begin
      inc_sec_s = 1'b0;
    end else if ((state_r == ST_RUN) && (cnt_r == CNT_LAST)) begin
      inc_sec_s = 1'b1;
    end else begin
      inc_sec_s = step_pulse_r;
    end
    blink_s   = (cnt_r >= CNT_HALF);
    running_s = (state_r == ST_RUN);
  end

  assign inc_sec = inc_sec_s;
  assign blink   = blink_s;
  assign running = running_s;

endmodule

// File: tb/tb_sec_tick_gen.sv
// Bench for sec_tick_gen with DIV=10, DB_CYCLES=4. The stimulus process
// pushes the cycle numbers at which inc_sec must pulse; a monitor pops one
// entry per observed pulse and compares the cycle number. Level outputs
// (running, blink) are checked directly at hand-computed cycles.
module tb_sec_tick_gen;

  logic clk = 1'b0;
  logic reset;
  logic run_btn;
  logic step_btn;
  logic set;
  logic inc_sec;
  logic blink;
  logic running;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int rel   = 0;
  int exp_q[$];

  sec_tick_gen #(
    .DIV       (10),
    .DB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_btn  (run_btn),
    .step_btn (step_btn),
    .set      (set),
    .inc_sec  (inc_sec),
    .blink    (blink),
    .running  (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to #1 after the edge that starts cycle c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: cycle %0d got %b expected %b", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: every inc_sec pulse consumes one expected cycle number.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (inc_sec === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tick_unexpected: inc_sec at cycle %0d, none expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e) begin
            n_err++;
            $display("FAIL tick_cycle: inc_sec at cycle %0d expected at cycle %0d (rel %0d)",
                     cyc, e, e - rel);
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    set      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rel   = cyc;   // this cycle is cycle 1 after release, count 0

    // Free running: ticks at cycles 10/20/30..., blink high for counts 5..9.
    foreach (exp_q[i]) exp_q.delete(i);
    for (int k = 0; k < 6; k++) exp_q.push_back(rel + 9 + 10 * k);
    check("rst_running", running, 1'b1);
    check("rst_blink", blink, 1'b0);
    wait_to(rel + 4);  check("blink_cnt4", blink, 1'b0);
    wait_to(rel + 5);  check("blink_cnt5", blink, 1'b1);
    wait_to(rel + 9);  check("blink_cnt9", blink, 1'b1);
    wait_to(rel + 10); check("blink_wrap", blink, 1'b0);

    // Bouncing run button: never stable for 4 cycles, so no press.
    for (int k = 0; k < 10; k++) begin
      wait_to(rel + 30 + 2 * k);
      run_btn = (k % 2 == 0) ? 1'b1 : 1'b0;
    end
    wait_to(rel + 50); run_btn = 1'b0;
    wait_to(rel + 55); check("bounce_running", running, 1'b1);

    // Clean run press at count 0: PAUSE 7 cycles later, count frozen at 7.
    wait_to(rel + 60); run_btn = 1'b1;
    wait_to(rel + 66); check("pause_not_yet", running, 1'b1);
    wait_to(rel + 67); check("pause_entered", running, 1'b0);
    check("pause_blink", blink, 1'b1);
    wait_to(rel + 68); run_btn = 1'b0;
    wait_to(rel + 100); check("pause_hold", running, 1'b0);
    check("pause_frozen_blink", blink, 1'b1);

    // Step held 30 cycles while paused: exactly one tick, one cycle after the press.
    exp_q.push_back(rel + 127);
    wait_to(rel + 120); step_btn = 1'b1;
    wait_to(rel + 150); step_btn = 1'b0;
    wait_to(rel + 160); check("step_still_paused", running, 1'b0);
    check("step_count_kept", blink, 1'b1);

    // Run and step together: resume, no step tick; count continues from 7.
    exp_q.push_back(rel + 179);
    exp_q.push_back(rel + 189);
    wait_to(rel + 170); run_btn = 1'b1; step_btn = 1'b1;
    wait_to(rel + 176); check("both_not_yet", running, 1'b0);
    wait_to(rel + 177); check("both_resumed", running, 1'b1);
    wait_to(rel + 180); run_btn = 1'b0; step_btn = 1'b0;

    // Set for 7 cycles from count 5: tick at R+199 suppressed, blink low.
    wait_to(rel + 195); set = 1'b1;
    wait_to(rel + 196); check("set_blink_a", blink, 1'b0);
    wait_to(rel + 201); check("set_blink_b", blink, 1'b0);
    wait_to(rel + 202); set = 1'b0;
    exp_q.push_back(rel + 211);
    exp_q.push_back(rel + 221);
    wait_to(rel + 207); check("post_set_blink", blink, 1'b1);

    // Reset at count 6: old boundary (R+231) dropped, new ticks from release.
    exp_q.push_back(rel + 239);
    exp_q.push_back(rel + 249);
    wait_to(rel + 228); reset = 1'b1;
    wait_to(rel + 229); check("reset_blink", blink, 1'b0);
    wait_to(rel + 230); reset = 1'b0;
    check("reset_running", running, 1'b1);
    wait_to(rel + 235); check("reset_blink_cnt5", blink, 1'b1);

    // Run button held across a reset: debounce restarts and the press lands after release.
    wait_to(rel + 252); run_btn = 1'b1;
    wait_to(rel + 254); reset = 1'b1;
    wait_to(rel + 256); reset = 1'b0;
    wait_to(rel + 262); check("held_reset_not_yet", running, 1'b1);
    wait_to(rel + 263); check("held_reset_pause", running, 1'b0);
    wait_to(rel + 270); run_btn = 1'b0;
    wait_to(rel + 300); check("final_paused", running, 1'b0);

    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_missing: no inc_sec seen, expected at cycle %0d", exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sec_tick_gen.md
SEC_TICK_GEN -- requirements
Module: sec_tick_gen

Interface
REQ-001 Parameter DIV, default 50_000_000, clk cycles per second tick (>= 4, even).
REQ-002 Parameter DB_CYCLES, default 500_000, consecutive stable cycles needed to accept a button level change (>= 2).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run_btn  input  1  raw asynchronous button; a debounced press toggles run/pause.
REQ-006 step_btn  input  1  raw asynchronous button; a debounced press issues one manual tick while paused.
REQ-007 set  input  1  time-set in progress; holds prescaler at zero and suppresses ticks.
REQ-008 inc_sec  output  1  one-cycle tick pulse to the seconds-units digit register.
REQ-009 blink  output  1  1 Hz square wave for the colon/set indicator, high during second half of each prescaler period.
REQ-010 running  output  1  high in RUN state, low in PAUSE.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounced level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch break restarts the count.
REQ-013 A press SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; release generates nothing; holding gives exactly one press.
REQ-014 FSM states SHALL be RUN and PAUSE; a run press toggles state, effective next cycle.
REQ-015 In RUN with set low, prescaler count SHALL advance 0..DIV-1 and wrap to 0.
REQ-016 inc_sec SHALL be high exactly in the cycle where state is RUN, set is low and count == DIV-1.
REQ-017 In PAUSE, count SHALL hold its value; a step press SHALL drive inc_sec high for exactly the following cycle (registered), count unchanged.
REQ-018 Step presses in RUN SHALL be ignored.
REQ-019 Run press and step press in the same cycle: toggle applied, step ignored.
REQ-020 Run press in the cycle count == DIV-1 in RUN: that cycle's inc_sec still issues, PAUSE from next cycle.
REQ-021 While set is high, count SHALL be forced to 0 each cycle and inc_sec SHALL be 0 (including any pending step pulse); FSM state unaffected.
REQ-022 After set falls in RUN, the next inc_sec SHALL occur DIV cycles after the first cycle with set low.
REQ-023 blink SHALL equal (count >= DIV/2), registered-free decode of the count register.
REQ-024 Prescaler width SHALL be $clog2(DIV); debounce counter width $clog2(DB_CYCLES+1); no overflow past terminal values.

Reset
REQ-025 On reset: state RUN, count 0, synchronizers 0, debounce counters 0, debounced levels 0, step pulse register 0.
REQ-026 Output values during/after reset: inc_sec 0, blink 0, running 1.
REQ-027 Reset asserted mid-count or mid-debounce SHALL discard all progress; first inc_sec occurs in the DIV-th cycle after reset deasserts.
REQ-028 A button held through reset deassertion SHALL register as a press once debounce completes.

Structure
REQ-029 Shared package clock_pkg SHALL hold the RUN/PAUSE state enum and default DIV/DB_CYCLES constants.
REQ-030 Sub-module btn_conditioner (synchronizer, debouncer, press edge; parameter DB_CYCLES) SHALL be instantiated once per button.
REQ-031 No combinational path from button inputs to any output.

Verification (DIV=10, DB_CYCLES=4)
REQ-032 Release reset, idle buttons -> inc_sec single-cycle pulses at cycles 10, 20, 30 after release; blink high cycles 6-10 of each period; running=1.
REQ-033 run_btn high 8 cycles -> running falls 2+4+1 cycles after rise, no inc_sec for next 50 cycles, count frozen; second press resumes from frozen count.
REQ-034 run_btn toggling every 2 cycles for 20 cycles -> no press, running stays 1, tick cadence unchanged.
REQ-035 Paused, step_btn held 30 cycles -> exactly one inc_sec pulse; simultaneous run and step press -> running toggles, no step tick.
REQ-036 set high 7 cycles starting at count 5 -> no inc_sec, blink 0 while set; next pulse exactly 10 cycles after set falls.
REQ-037 reset pulsed at count 6 -> no pulse at old boundary; next pulse 10 cycles after release, running=1.
